digital_frontend: RTL and testbench

DIGITAL_FRONTEND -- requirements
Module: digital_frontend

---
 rtl/digital_frontend.sv | 183 ++++++++++++++++++
 tb/tb_digital_frontend.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digital_frontend.sv
// Stereo PCM front end: test-sample bypass or I2S receiver into one registered output.
// The I2S receiver is built only when DIGITAL_FRONTEND_I2S_RX_EN is defined.
module digital_frontend #(
  parameter int DATA_W = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               input_sel,
  input  logic                     i2s_bclk,
  input  logic                     i2s_lrclk,
  input  logic                     i2s_sd,
  input  logic                     spdif_in,
  input  logic                     usb_dp,
  input  logic                     usb_dm,
  input  logic                     test_valid,
  input  logic signed [DATA_W-1:0] test_l,
  input  logic signed [DATA_W-1:0] test_r,
  output logic                     pcm_valid,
  output logic signed [DATA_W-1:0] pcm_l,
  output logic signed [DATA_W-1:0] pcm_r
);

  logic [1:0]               sel_q;
  logic                     rdy_q;
  logic                     sel_chg;
  logic [1:0]               spdif_sync_q, dp_sync_q, dm_sync_q;
  logic                     pcm_valid_q, pcm_valid_d;
  logic signed [DATA_W-1:0] pcm_l_q, pcm_l_d, pcm_r_q, pcm_r_d;
  logic                     i2s_pair_vld;
  logic signed [DATA_W-1:0] i2s_l, i2s_r;
  logic                     unused_pins;

  assign sel_chg = (input_sel != sel_q);

  // rdy_q blocks the first edge after reset release so no sample lands on it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q        <= '0;
      rdy_q        <= 1'b0;
      spdif_sync_q <= '0;
      dp_sync_q    <= '0;
      dm_sync_q    <= '0;
      pcm_valid_q  <= 1'b0;
      pcm_l_q      <= '0;
      pcm_r_q      <= '0;
    end else begin
      sel_q        <= input_sel;
      rdy_q        <= 1'b1;
      spdif_sync_q <= {spdif_sync_q[0], spdif_in};
      dp_sync_q    <= {dp_sync_q[0], usb_dp};
      dm_sync_q    <= {dm_sync_q[0], usb_dm};
      pcm_valid_q  <= pcm_valid_d;
      pcm_l_q      <= pcm_l_d;
      pcm_r_q      <= pcm_r_d;
    end
  end

  always_comb begin
    pcm_valid_d = 1'b0;
    pcm_l_d     = pcm_l_q;
    pcm_r_d     = pcm_r_q;
    if (rdy_q && !sel_chg) begin
      if (input_sel == 2'd0 && test_valid) begin
        pcm_valid_d = 1'b1;
        pcm_l_d     = test_l;
        pcm_r_d     = test_r;
      end else if (i2s_pair_vld) begin
        pcm_valid_d = 1'b1;
        pcm_l_d     = i2s_l;
        pcm_r_d     = i2s_r;
      end
    end
  end

  assign pcm_valid = pcm_valid_q;
  assign pcm_l     = pcm_l_q;
  assign pcm_r     = pcm_r_q;

`ifdef DIGITAL_FRONTEND_I2S_RX_EN
  localparam int               CNT_W   = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);

  logic [1:0]        bclk_sync_q, lr_sync_q, sd_sync_q;
  logic              bclk_prev_q;
  logic              lr_prev_q, lr_prev_d;
  logic              fsync_q, fsync_d;
  logic              lvld_q, lvld_d;
  logic [DATA_W-1:0] sh_q, sh_d, sh_in, lhold_q, lhold_d, word;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_in;
  logic              bclk_rise, i2s_act, lr_chg;

  function automatic logic [DATA_W-1:0] left_align(input logic [DATA_W-1:0] w,
                                                   input logic [CNT_W-1:0]  n);
    return w << (CNT_MAX - n);
  endfunction

  assign bclk_rise = bclk_sync_q[1] & ~bclk_prev_q;
  assign i2s_act   = (input_sel == 2'd1) && !sel_chg;
  assign lr_chg    = (lr_sync_q[1] != lr_prev_q);

  // fsync_q stays low until the first lrclk edge, so the partial word ahead of it is dropped
  always_comb begin
    sh_d         = sh_q;
    cnt_d        = cnt_q;
    lr_prev_d    = lr_prev_q;
    fsync_d      = fsync_q;
    lhold_d      = lhold_q;
    lvld_d       = lvld_q;
    sh_in        = sh_q;
    cnt_in       = cnt_q;
    word         = '0;
    i2s_pair_vld = 1'b0;
    if (!i2s_act) begin
      sh_d      = '0;
      cnt_d     = '0;
      lr_prev_d = 1'b0;
      fsync_d   = 1'b0;
      lvld_d    = 1'b0;
    end else if (bclk_rise) begin
      if (cnt_q < CNT_MAX) begin
        sh_in  = {sh_q[DATA_W-2:0], sd_sync_q[1]};
        cnt_in = cnt_q + 1'b1;
      end
      lr_prev_d = lr_sync_q[1];
      if (lr_chg) begin
        sh_d    = '0;
        cnt_d   = '0;
        fsync_d = 1'b1;
        word    = left_align(sh_in, cnt_in);
        if (fsync_q) begin
          if (!lr_prev_q) begin
            lhold_d = word;
            lvld_d  = 1'b1;
          end else if (lvld_q) begin
            i2s_pair_vld = 1'b1;
            lvld_d       = 1'b0;
          end
        end
      end else begin
        sh_d  = sh_in;
        cnt_d = cnt_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
      sd_sync_q   <= '0;
      bclk_prev_q <= 1'b0;
      lr_prev_q   <= 1'b0;
      fsync_q     <= 1'b0;
      lvld_q      <= 1'b0;
      sh_q        <= '0;
      cnt_q       <= '0;
      lhold_q     <= '0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[0], i2s_bclk};
      lr_sync_q   <= {lr_sync_q[0], i2s_lrclk};
      sd_sync_q   <= {sd_sync_q[0], i2s_sd};
      bclk_prev_q <= bclk_sync_q[1];
      lr_prev_q   <= lr_prev_d;
      fsync_q     <= fsync_d;
      lvld_q      <= lvld_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      lhold_q     <= lhold_d;
    end
  end

  assign i2s_l       = $signed(lhold_q);
  assign i2s_r       = $signed(word);
  assign unused_pins = ^{spdif_sync_q[1], dp_sync_q[1], dm_sync_q[1]};
`else
  assign i2s_pair_vld = 1'b0;
  assign i2s_l        = '0;
  assign i2s_r        = '0;
  assign unused_pins  = ^{spdif_sync_q[1], dp_sync_q[1], dm_sync_q[1],
                          i2s_bclk, i2s_lrclk, i2s_sd};
`endif

endmodule

// File: tb/tb_digital_frontend.sv
// Scoreboard bench for digital_frontend: stimulus pushes expected stereo pairs,
// a monitor pops them whenever pcm_valid is seen and checks hold values otherwise.
module tb_digital_frontend;

`ifdef DIGITAL_FRONTEND_I2S_RX_EN
  localparam bit I2S_BUILT = 1'b1;
`else
  localparam bit I2S_BUILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  input_sel = 2'd0;
  logic        i2s_bclk = 1'b0, i2s_lrclk = 1'b0, i2s_sd = 1'b0;
  logic        spdif_in = 1'b0, usb_dp = 1'b0, usb_dm = 1'b0;
  logic        test_valid = 1'b0;
  logic [23:0] test_l = '0, test_r = '0;
  logic        pcm_valid;
  logic [23:0] pcm_l, pcm_r;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    int          dl;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [23:0] last_l = '0, last_r = '0;
  int          fw[8];
  logic [31:0] fl[8], fr[8];

  digital_frontend #(.DATA_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .input_sel(input_sel),
    .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sd(i2s_sd),
    .spdif_in(spdif_in), .usb_dp(usb_dp), .usb_dm(usb_dm),
    .test_valid(test_valid), .test_l(test_l), .test_r(test_r),
    .pcm_valid(pcm_valid), .pcm_l(pcm_l), .pcm_r(pcm_r)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void push_exp(logic [23:0] l, logic [23:0] r, int dl);
    exp_t e;
    e.l = l;
    e.r = r;
    e.dl = dl;
    sb.push_back(e);
  endfunction

  // First 24 bits of a w-bit word, left-aligned into 24 bits
  function automatic logic [23:0] align24(logic [31:0] v, int w);
    if (w >= 24) return 24'(v >> (w - 24));
    else         return 24'(v << (24 - w));
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("reset_pcm_valid", {31'b0, pcm_valid}, 32'd0);
      chk("reset_pcm_l", {8'b0, pcm_l}, 32'd0);
      chk("reset_pcm_r", {8'b0, pcm_r}, 32'd0);
    end else if (pcm_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got pcm_valid=1 l=%h r=%h, required no pulse (cycle %0d)",
                 pcm_l, pcm_r, cyc);
      end else begin
        e = sb.pop_front();
        chk("pulse_pcm_l", {8'b0, pcm_l}, {8'b0, e.l});
        chk("pulse_pcm_r", {8'b0, pcm_r}, {8'b0, e.r});
        n_cmp++;
        if (cyc > e.dl) begin
          n_bad++;
          $display("FAIL pulse_latency: got cycle %0d, required by cycle %0d", cyc, e.dl);
        end
        last_l = e.l;
        last_r = e.r;
      end
    end else begin
      chk("hold_pcm_l", {8'b0, pcm_l}, {8'b0, last_l});
      chk("hold_pcm_r", {8'b0, pcm_r}, {8'b0, last_r});
    end
  end

  task automatic strobe(input logic [23:0] l, input logic [23:0] r, input bit expect_pulse);
    @(negedge clk);
    test_valid = 1'b1;
    test_l     = l;
    test_r     = r;
    if (expect_pulse) push_exp(l, r, cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      test_valid = 1'b0;
    end
  endtask

  task automatic async_reset(input int hold);
    @(negedge clk);
    #2;
    rst_n      = 1'b0;
    sb.delete();
    last_l     = '0;
    last_r     = '0;
    test_valid = 1'b0;
    i2s_bclk   = 1'b0;
    i2s_lrclk  = 1'b0;
    i2s_sd     = 1'b0;
    #1;
    chk("async_reset_pcm_valid", {31'b0, pcm_valid}, 32'd0);
    chk("async_reset_pcm_l", {8'b0, pcm_l}, 32'd0);
    chk("async_reset_pcm_r", {8'b0, pcm_r}, 32'd0);
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One bclk period of 8 clk: data changes while bclk is low, sampled on its rise
  task automatic bper(input logic lr, input logic sd, input bit push,
                      input logic [23:0] el, input logic [23:0] er);
    @(negedge clk);
    i2s_bclk  = 1'b0;
    i2s_lrclk = lr;
    i2s_sd    = sd;
    repeat (4) @(negedge clk);
    i2s_bclk = 1'b1;
    if (push && I2S_BUILT) push_exp(el, er, cyc + 4);
    repeat (3) @(negedge clk);
  endtask

  // Frames fw/fl/fr[0..nfr-1]; every frame after the first yields one pair.
  task automatic run_i2s(input int nfr, input int abort_k);
    logic        carry, b;
    int          w;
    bit          p;
    logic [23:0] el, er;
    test_valid = 1'b0;
    i2s_bclk   = 1'b0;
    i2s_lrclk  = 1'b0;
    i2s_sd     = 1'b0;
    @(negedge clk);
    input_sel = 2'd2;
    repeat (2) @(negedge clk);
    input_sel = 2'd1;
    repeat (2) @(negedge clk);
    carry = 1'b0;
    for (int f = 0; f < nfr; f++) begin
      w = fw[f];
      for (int k = 0; k < 2 * w; k++) begin
        if (k == 0)         b = carry;
        else if (k - 1 < w) b = fl[f][w - k];
        else                b = fr[f][2 * w - k];
        p  = (k == 0) && (f >= 2);
        el = '0;
        er = '0;
        if (p) begin
          el = align24(fl[f-1], fw[f-1]);
          er = align24(fr[f-1], fw[f-1]);
        end
        bper(k >= w, b, p, el, er);
        if (f == nfr - 1 && k == abort_k) begin
          async_reset(4);
          repeat (3) @(negedge clk);
          return;
        end
      end
      carry = fr[f][0];
    end
    p  = (nfr >= 2);
    el = align24(fl[nfr-1], fw[nfr-1]);
    er = align24(fr[nfr-1], fw[nfr-1]);
    bper(1'b0, carry, p, el, er);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got no end of stimulus by %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    // Strobe on the first edge after release must not produce a pulse
    rst_n      = 1'b1;
    test_valid = 1'b1;
    test_l     = 24'h111111;
    test_r     = 24'h222222;
    strobe(24'h333333, 24'h444444, 1'b1);
    for (int i = 1; i <= 10; i++) strobe(24'(i), 24'hFFFFFF - 24'(i - 1), 1'b1);
    idle(4);

    repeat (300) begin
      @(negedge clk);
      test_valid = 1'($urandom_range(0, 1));
      test_l     = 24'($urandom);
      test_r     = 24'($urandom);
      i2s_bclk   = 1'($urandom);
      i2s_lrclk  = 1'($urandom);
      i2s_sd     = 1'($urandom);
      if (test_valid) push_exp(test_l, test_r, cyc + 1);
    end
    idle(2);

    // A strobe in the cycle input_sel changes back to 0 is dropped
    @(negedge clk);
    input_sel  = 2'd2;
    test_valid = 1'b1;
    test_l     = 24'h777777;
    repeat (3) @(negedge clk);
    input_sel = 2'd0;
    test_l    = 24'hABCDEF;
    test_r    = 24'h010203;
    strobe(24'h5A5A5A, 24'hA5A5A5, 1'b1);
    idle(3);
    async_reset(3);
    idle(3);

    for (int s = 2; s <= 3; s++) begin
      @(negedge clk);
      input_sel = 2'(s);
      repeat (500) begin
        @(negedge clk);
        test_valid = 1'($urandom);
        test_l     = 24'($urandom);
        test_r     = 24'($urandom);
        spdif_in   = 1'($urandom);
        usb_dp     = 1'($urandom);
        usb_dm     = 1'($urandom);
        i2s_bclk   = 1'($urandom);
        i2s_lrclk  = 1'($urandom);
        i2s_sd     = 1'($urandom);
      end
    end

    for (int f = 0; f < 4; f++) begin
      fw[f] = 32;
      fl[f] = 32'h12345600;
      fr[f] = 32'hABCDEF00;
    end
    run_i2s(4, -1);

    for (int f = 0; f < 3; f++) begin
      fw[f] = 16;
      fl[f] = 32'h00001234;
      fr[f] = 32'h0000ABCD;
    end
    run_i2s(3, -1);

    for (int f = 0; f < 5; f++) begin
      fw[f] = 16 + 8 * $urandom_range(0, 2);
      fl[f] = $urandom;
      fr[f] = $urandom;
    end
    run_i2s(5, -1);

    for (int f = 0; f < 2; f++) begin
      fw[f] = 32;
      fl[f] = 32'h0F0F0F00;
      fr[f] = 32'hF0F0F000;
    end
    run_i2s(2, 42);

    for (int f = 0; f < 3; f++) begin
      fw[f] = 32;
      fl[f] = 32'h12345600;
      fr[f] = 32'hABCDEF00;
    end
    run_i2s(3, -1);

    idle(10);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
